regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (RegWrite/write_add/write_data) among NUM_REQ

---
 rtl/mips_rf_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
// Shared register-file constants for the MIPS writeback path.
package mips_rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant generator. The search starts at the internal
// pointer and wraps. The pointer moves to the slot after the winner whenever
// the grant is consumed.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] win;
  logic             found;

  // Scan requesters from ptr upward with wrap, granting the first valid one.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        win      = idx;
      end
    end
  end

  // Pointer moves past the winner on a transfer and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port. It also holds a
// pending-write scoreboard so that decode can stall reads of in-flight registers.
module regfile_wb_arbiter
  import mips_rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_add,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_add,
  input  logic [ADDR_W-1:0]         chk_add1,
  input  logic [ADDR_W-1:0]         chk_add2,
  output logic                      chk_busy1,
  output logic                      chk_busy2,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         write_add,
  output logic [DATA_W-1:0]         write_data,
  output logic                      rsv_err
);

  localparam logic [ADDR_W-1:0] ZERO_ADD = ADDR_W'(ZERO_REG);

  logic [NUM_REQ-1:0]  req_gated;
  logic                xfer_p0;
  logic [ADDR_W-1:0]   win_add_p0;
  logic [DATA_W-1:0]   win_data_p0;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                rsv_hit;

  // While reset is asserted no requester is visible, so no ready leaks out.
  assign req_gated = req_valid & {NUM_REQ{~rst}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_gated),
    .advance (xfer_p0),
    .gnt     (req_ready)
  );

  // Select the winning slices with a one-hot AND-OR mux.
  always_comb begin
    xfer_p0     = |req_ready;
    win_add_p0  = '0;
    win_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_add_p0  = win_add_p0  | (req_add[i*ADDR_W +: ADDR_W]  & {ADDR_W{req_ready[i]}});
      win_data_p0 = win_data_p0 | (req_data[i*DATA_W +: DATA_W] & {DATA_W{req_ready[i]}});
    end
  end

  // ---- stage boundary: winner registered onto the register-file port ----
  // Register the winner. A write to $0 completes the handshake without writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      write_add  <= '0;
      write_data <= '0;
    end else if (xfer_p0) begin
      RegWrite   <= (win_add_p0 != ZERO_ADD);
      write_add  <= win_add_p0;
      write_data <= win_data_p0;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  // Next scoreboard state. The clear is applied first so that a same-cycle
  // reservation from a newer producer wins. Bit 0 is never pending.
  always_comb begin
    pending_nxt = pending;
    rsv_hit     = 1'b0;
    if (xfer_p0 && (win_add_p0 != ZERO_ADD)) begin
      pending_nxt[win_add_p0] = 1'b0;
    end
    if (rsv_valid && (rsv_add != ZERO_ADD)) begin
      rsv_hit              = pending[rsv_add];
      pending_nxt[rsv_add] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // The scoreboard and the sticky double-reservation flag both clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      rsv_err <= 1'b0;
    end else begin
      pending <= pending_nxt;
      rsv_err <= rsv_err | rsv_hit;
    end
  end

  // A source is busy while reserved or while its write sits on the port.
  always_comb begin
    chk_busy1 = (chk_add1 != ZERO_ADD) &&
                (pending[chk_add1] || (RegWrite && (write_add == chk_add1)));
    chk_busy2 = (chk_add2 != ZERO_ADD) &&
                (pending[chk_add2] || (RegWrite && (write_add == chk_add2)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with two requesters.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_add;
  logic [63:0] req_data;
  logic        rsv_valid;
  logic [4:0]  rsv_add;
  logic [4:0]  chk_add1;
  logic [4:0]  chk_add2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic        RegWrite;
  logic [4:0]  write_add;
  logic [31:0] write_data;
  logic        rsv_err;

  int checks;
  int errors;

  regfile_wb_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (32),
    .ADDR_W  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_add    (req_add),
    .req_data   (req_data),
    .rsv_valid  (rsv_valid),
    .rsv_add    (rsv_add),
    .chk_add1   (chk_add1),
    .chk_add2   (chk_add2),
    .chk_busy1  (chk_busy1),
    .chk_busy2  (chk_busy2),
    .RegWrite   (RegWrite),
    .write_add  (write_add),
    .write_data (write_data),
    .rsv_err    (rsv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [1:0] exp_rdy [4];
    logic [4:0] exp_add [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_add = '{5'd3, 5'd4, 5'd3, 5'd4};
    checks = 0;
    errors = 0;

    // 1: reset with both requesters valid
    rst       = 1'b1;
    req_valid = 2'b11;
    req_add   = {5'd4, 5'd3};
    req_data  = {32'hA1, 32'hA0};
    rsv_valid = 1'b0;
    rsv_add   = 5'd0;
    chk_add1  = 5'd5;
    chk_add2  = 5'd6;
    settle();
    chk("rst_ready_comb", req_ready, 2'b00);
    tick();
    tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_write_add", write_add, 5'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_rsv_err", rsv_err, 1'b0);
    chk("rst_busy1", chk_busy1, 1'b0);
    chk("rst_busy2", chk_busy2, 1'b0);

    // 2: single write from requester 1
    rst       = 1'b0;
    req_valid = 2'b10;
    req_add   = {5'd7, 5'd3};
    req_data  = {32'hDEADBEEF, 32'hA0};
    settle();
    chk("single_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("single_regwrite", RegWrite, 1'b1);
    chk("single_add", write_add, 5'd7);
    chk("single_data", write_data, 32'hDEADBEEF);
    tick();
    chk("single_regwrite_off", RegWrite, 1'b0);
    chk("single_add_hold", write_add, 5'd7);

    // 3: contention, pointer is back at 0 after the grant to requester 1
    req_valid = 2'b11;
    req_add   = {5'd4, 5'd3};
    req_data  = {32'hA1, 32'hA0};
    settle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_ready_%0d", i), req_ready, exp_rdy[i]);
      tick();
      chk($sformatf("cont_regwrite_%0d", i), RegWrite, 1'b1);
      chk($sformatf("cont_add_%0d", i), write_add, exp_add[i]);
      chk($sformatf("cont_data_%0d", i), write_data, (exp_add[i] == 5'd3) ? 32'hA0 : 32'hA1);
    end
    req_valid = 2'b00;
    tick();
    chk("cont_regwrite_off", RegWrite, 1'b0);

    // 4: write to $0 completes the handshake but never writes
    req_valid = 2'b01;
    req_add   = {5'd4, 5'd0};
    req_data  = {32'hA1, 32'd5};
    chk_add1  = 5'd3;
    settle();
    chk("zero_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("zero_regwrite", RegWrite, 1'b0);
    chk("zero_busy_unchanged", chk_busy1, 1'b0);

    // 5: scoreboard reserve, clear through a write, double reserve
    rsv_valid = 1'b1;
    rsv_add   = 5'd9;
    chk_add1  = 5'd9;
    settle();
    chk("sb_busy_before", chk_busy1, 1'b0);
    tick();
    rsv_valid = 1'b0;
    settle();
    chk("sb_busy_reserved", chk_busy1, 1'b1);
    req_valid = 2'b10;
    req_add   = {5'd9, 5'd0};
    req_data  = {32'h99, 32'd0};
    settle();
    chk("sb_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    settle();
    chk("sb_regwrite", RegWrite, 1'b1);
    chk("sb_busy_on_port", chk_busy1, 1'b1);
    tick();
    chk("sb_busy_cleared", chk_busy1, 1'b0);
    chk("sb_err_clear", rsv_err, 1'b0);
    rsv_valid = 1'b1;
    tick();
    chk("sb_err_first_rsv", rsv_err, 1'b0);
    tick();
    rsv_valid = 1'b0;
    chk("sb_err_double", rsv_err, 1'b1);
    tick();
    chk("sb_err_sticky", rsv_err, 1'b1);

    // 6: same-cycle set and clear on reg 12, then reset mid-write
    rsv_valid = 1'b1;
    rsv_add   = 5'd12;
    chk_add2  = 5'd12;
    tick();
    req_valid = 2'b01;
    req_add   = {5'd0, 5'd12};
    req_data  = {32'd0, 32'h12};
    settle();
    chk("sc_ready", req_ready, 2'b01);
    tick();
    rsv_valid = 1'b0;
    req_valid = 2'b00;
    settle();
    chk("sc_regwrite", RegWrite, 1'b1);
    chk("sc_add", write_add, 5'd12);
    tick();
    chk("sc_regwrite_off", RegWrite, 1'b0);
    chk("sc_set_wins", chk_busy2, 1'b1);
    req_valid = 2'b01;
    tick();
    chk("mid_regwrite", RegWrite, 1'b1);
    rst       = 1'b1;
    req_valid = 2'b11;
    settle();
    chk("mid_ready_rst", req_ready, 2'b00);
    tick();
    chk("mid_regwrite_drop", RegWrite, 1'b0);
    chk("mid_busy12", chk_busy2, 1'b0);
    chk("mid_busy9", chk_busy1, 1'b0);
    chk("mid_rsv_err", rsv_err, 1'b0);
    rst = 1'b0;
    settle();
    chk("post_rst_ptr", req_ready, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
